sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_pkg.sv | 22 ++
 rtl/sdram_arbiter_if.sv | 12 +
 rtl/sdram_phase.sv | 18 +
 rtl/sdram_arbiter.sv | 76 +++++++
 tb/tb_sdram_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arbiter_pkg.sv
// sdram_arbiter_pkg: owner encoding, slot phase constants and shared types for the SDRAM arbiter
package sdram_arbiter_pkg;
  typedef logic [24:0] addr_t;
  typedef logic [3:0] phase_t;
  typedef struct packed {
    addr_t addr;
    logic we;
    logic [7:0] din;
    logic aux;
  } sd_cmd_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU = 2'd1;
  localparam logic [1:0] OWN_DMA = 2'd2;
  localparam phase_t ARB_PHASE = 4'd12;
  localparam phase_t WR_ACK_PHASE = 4'd2;
  localparam phase_t LAST_PHASE = 4'd13;
  localparam int READ_PHASE_DEF = 5;
  // 14-slot counter locked to clkref: parks at LAST_PHASE until clkref rises, at 0 until it falls
  function automatic phase_t next_phase(input phase_t ph, input logic clkref);
    return (ph == LAST_PHASE) ? (clkref ? 4'd0 : LAST_PHASE) : (ph == 4'd0 && clkref) ? 4'd0 : ph + 4'd1;
  endfunction
endpackage

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: one requester port (CPU or DMA) of the SDRAM arbiter
interface sdram_arbiter_if;
  logic req;
  sdram_arbiter_pkg::addr_t addr;
  logic we;
  logic [7:0] din;
  logic aux;
  logic ack;
  logic [15:0] dout;
  modport master(output req, addr, we, din, aux, input ack, dout);
  modport slave(input req, addr, we, din, aux, output ack, dout);
endinterface

// File: rtl/sdram_phase.sv
// sdram_phase: slot phase counter shared with the sdram controller
module sdram_phase
  import sdram_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   init_n,
  input  logic   clkref,
  output phase_t ph
);
  phase_t ph_q, ph_d;
  // next slot, held while waiting for the clkref edge
  always_comb ph_d = next_phase(ph_q, clkref);
  // phase register, restarts at slot 0 on reset
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) ph_q <= '0;
    else ph_q <= ph_d;
  assign ph = ph_q;
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port (CPU/DMA) slot arbiter in front of a single-port SDRAM controller
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int READ_PHASE = READ_PHASE_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           init_n,
  input  logic           clkref,
  input  logic           ram_ready,
  sdram_arbiter_if.slave cpu,
  sdram_arbiter_if.slave dma,
  output addr_t          sd_addr,
  output logic           sd_we,
  output logic [7:0]     sd_din,
  output logic           sd_aux,
  input  logic [15:0]    sd_dout
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam phase_t RD_PHASE = phase_t'(READ_PHASE);
  phase_t ph;
  logic arb, done;
  logic [1:0] win, own_q, own_d;
  logic [SW-1:0] starve_q, starve_d;
  sd_cmd_t cmd_q, cmd_d;
  logic cack_q, cack_d, dack_q, dack_d;
  logic [15:0] cdout_q, cdout_d, ddout_q, ddout_d;
  sdram_phase u_phase (
    .clk    (clk),
    .init_n (init_n),
    .clkref (clkref),
    .ph     (ph)
  );
  // pick the slot owner at ARB_PHASE and complete the current owner's access at its ack phase
  always_comb begin
    arb = ph == ARB_PHASE;
    win = !ram_ready ? OWN_NONE : (dma.req && starve_q == STARVE_TOP) ? OWN_DMA : cpu.req ? OWN_CPU : dma.req ? OWN_DMA : OWN_NONE;
    own_d = arb ? win : own_q;
    starve_d = !arb ? starve_q : (!dma.req || win == OWN_DMA) ? '0 : (win == OWN_CPU && starve_q != STARVE_TOP) ? starve_q + SW'(1) : starve_q;
    cmd_d = !arb ? cmd_q : win == OWN_CPU ? {cpu.addr, cpu.we, cpu.din, cpu.aux} : win == OWN_DMA ? {dma.addr, dma.we, dma.din, dma.aux} : {cmd_q.addr, 1'b0, cmd_q.din, cmd_q.aux};
    done = own_q != OWN_NONE && (cmd_q.we ? ph == WR_ACK_PHASE : ph == RD_PHASE);
    cack_d = done && own_q == OWN_CPU;
    dack_d = done && own_q == OWN_DMA;
    cdout_d = (cack_d && !cmd_q.we) ? sd_dout : cdout_q;
    ddout_d = (dack_d && !cmd_q.we) ? sd_dout : ddout_q;
  end
  // slot state; reset abandons any access in flight without an ack
  always_ff @(posedge clk or negedge init_n)
    if (!init_n) begin
      own_q <= OWN_NONE;
      starve_q <= '0;
      cmd_q <= '0;
      cack_q <= 1'b0;
      dack_q <= 1'b0;
      cdout_q <= '0;
      ddout_q <= '0;
    end else begin
      own_q <= own_d;
      starve_q <= starve_d;
      cmd_q <= cmd_d;
      cack_q <= cack_d;
      dack_q <= dack_d;
      cdout_q <= cdout_d;
      ddout_q <= ddout_d;
    end
  assign sd_addr = cmd_q.addr;
  assign sd_we = cmd_q.we;
  assign sd_din = cmd_q.din;
  assign sd_aux = cmd_q.aux;
  assign cpu.ack = cack_q;
  assign cpu.dout = cdout_q;
  assign dma.ack = dack_q;
  assign dma.dout = ddout_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a slot-level model
module tb_sdram_arbiter;
  localparam int RP = 5;
  localparam int SMAX = 4;
  logic clk = 0, init_n = 1, clkref = 0, ram_ready = 0;
  logic [24:0] sd_addr;
  logic sd_we, sd_aux;
  logic [7:0] sd_din;
  logic [15:0] sd_dout = 0;
  bit hold_hi = 0, dout_fix = 0, chk_en = 0;
  int n_cmp = 0, n_bad = 0;
  sdram_arbiter_if cpu ();
  sdram_arbiter_if dma ();
  sdram_arbiter #(.READ_PHASE(RP), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .init_n(init_n), .clkref(clkref), .ram_ready(ram_ready),
    .cpu(cpu), .dma(dma),
    .sd_addr(sd_addr), .sd_we(sd_we), .sd_din(sd_din), .sd_aux(sd_aux), .sd_dout(sd_dout)
  );
  always #5 clk = ~clk;
  // model: slot phase, who owns the current 14-clk slot, and what the outputs must be
  int mph = 0, mstarve = 0, mown = 0;
  logic [24:0] e_addr = 0;
  logic e_we = 0, e_aux = 0, e_cack = 0, e_dack = 0;
  logic [7:0] e_din = 0;
  logic [15:0] e_cdout = 0, e_ddout = 0;
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      mph = 0; mstarve = 0; mown = 0;
      e_addr = 0; e_we = 0; e_din = 0; e_aux = 0;
      e_cack = 0; e_dack = 0; e_cdout = 0; e_ddout = 0;
    end else begin
      e_cack = 0; e_dack = 0;
      if (mown != 0 && (e_we ? mph == 2 : mph == RP)) begin
        if (mown == 1) begin e_cack = 1; if (!e_we) e_cdout = sd_dout; end
        else begin e_dack = 1; if (!e_we) e_ddout = sd_dout; end
      end
      if (mph == 12) begin
        int w;
        w = 0;
        if (ram_ready) w = (dma.req && mstarve == SMAX) ? 2 : cpu.req ? 1 : dma.req ? 2 : 0;
        if (!dma.req || w == 2) mstarve = 0;
        else if (w == 1 && mstarve < SMAX) mstarve++;
        if (w == 1) begin e_addr = cpu.addr; e_we = cpu.we; e_din = cpu.din; e_aux = cpu.aux; end
        else if (w == 2) begin e_addr = dma.addr; e_we = dma.we; e_din = dma.din; e_aux = dma.aux; end
        else e_we = 0;
        mown = w;
      end
      if (mph == 13) mph = clkref ? 0 : 13;
      else if (!(mph == 0 && clkref)) mph++;
    end
  end
  // clkref follows the model phase so the counter runs freely unless held high
  always @(negedge clk) begin
    #1;
    clkref = hold_hi || mph >= 7;
    sd_dout = dout_fix ? 16'hBEEF : 16'($urandom);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // every cycle, all outputs against the model
  always @(negedge clk) if (chk_en) begin
    chk("cpu_ack", cpu.ack, e_cack);
    chk("dma_ack", dma.ack, e_dack);
    chk("cpu_dout", cpu.dout, e_cdout);
    chk("dma_dout", dma.dout, e_ddout);
    chk("sd_addr", sd_addr, e_addr);
    chk("sd_we", sd_we, e_we);
    chk("sd_din", sd_din, e_din);
    chk("sd_aux", sd_aux, e_aux);
  end
  task automatic step();
    @(negedge clk);
    #2;
  endtask
  task automatic wait_ack(input bit is_dma, input int maxc, output int took);
    took = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if ((is_dma ? dma.ack : cpu.ack) === 1'b1) begin took = i; break; end
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int took, cnt, wcnt, na;
    logic [9:0] seq;
    bit found;
    cpu.req = 0; cpu.addr = 0; cpu.we = 0; cpu.din = 0; cpu.aux = 0;
    dma.req = 0; dma.addr = 0; dma.we = 0; dma.din = 0; dma.aux = 0;
    #1 init_n = 0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_sd_we", sd_we, 0);
    chk("rst_sd_addr", sd_addr, 0);
    chk("rst_cpu_dout", cpu.dout, 0);
    init_n = 1;
    ram_ready = 1;
    // CPU read
    dout_fix = 1; cpu.addr = 25'h00400; cpu.we = 0; cpu.req = 1;
    wait_ack(0, 60, took);
    chk("rd_ack_seen", took > 0, 1);
    chk("rd_cpu_dout", cpu.dout, 16'hBEEF);
    chk("rd_sd_addr", sd_addr, 25'h00400);
    chk("rd_dma_ack", dma.ack, 0);
    chk("rd_model_phase", mph, RP + 1);
    cpu.req = 0; dout_fix = 0;
    // CPU write
    cpu.addr = 25'h1_2345; cpu.we = 1; cpu.din = 8'h5A; cpu.aux = 1; cpu.req = 1;
    wait_ack(0, 60, took);
    chk("wr_ack_seen", took > 0, 1);
    chk("wr_sd_we", sd_we, 1);
    chk("wr_sd_din", sd_din, 8'h5A);
    chk("wr_sd_aux", sd_aux, 1);
    chk("wr_dma_ack", dma.ack, 0);
    chk("wr_model_phase", mph, 3);
    cpu.req = 0; cpu.we = 0; cpu.aux = 0;
    // both ports requesting continuously
    cpu.addr = 25'h00111; dma.addr = 25'h00222; dma.we = 0;
    cpu.req = 1; dma.req = 1;
    seq = '0; na = 0;
    for (int i = 0; i < 220 && na < 10; i++) begin
      step();
      if (cpu.ack === 1'b1 || dma.ack === 1'b1) begin
        seq = {seq[8:0], dma.ack};
        na += int'(cpu.ack) + int'(dma.ack);
      end
    end
    chk("grant_seq", seq, 10'b0000100001);
    chk("grant_acks", na, 10);
    cpu.req = 0; dma.req = 0;
    // idle, then ram not ready
    repeat (14) step();
    cnt = 0; wcnt = 0;
    repeat (42) begin step(); cnt += int'(cpu.ack) + int'(dma.ack); wcnt += int'(sd_we); end
    chk("idle_acks", cnt, 0);
    chk("idle_sd_we", wcnt, 0);
    ram_ready = 0; cpu.req = 1; cpu.addr = 25'h0ABCD;
    cnt = 0;
    repeat (42) begin step(); cnt += int'(cpu.ack) + int'(dma.ack); end
    chk("notready_acks", cnt, 0);
    ram_ready = 1;
    wait_ack(0, 40, took);
    chk("ready_ack_seen", took > 0, 1);
    cpu.req = 0;
    // clkref held high parks the phase at 0
    hold_hi = 1; cpu.addr = 25'h0F00D; cpu.req = 1;
    cnt = 0;
    repeat (30) begin step(); cnt += int'(cpu.ack) + int'(dma.ack); end
    chk("hold_acks", cnt, 0);
    chk("hold_model_phase", mph, 0);
    hold_hi = 0;
    wait_ack(0, 30, took);
    chk("release_ack_seen", took > 0, 1);
    cpu.req = 0;
    // reset in the middle of a DMA read
    dma.addr = 25'h1_5551; dma.we = 0; dma.req = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin step(); found = mown == 2 && mph == 3; end
    chk("dma_ph3_found", found, 1);
    init_n = 0;
    #1;
    chk("arst_dma_ack", dma.ack, 0);
    chk("arst_cpu_ack", cpu.ack, 0);
    chk("arst_sd_addr", sd_addr, 0);
    chk("arst_sd_we", sd_we, 0);
    chk("arst_cpu_dout", cpu.dout, 0);
    chk("arst_dma_dout", dma.dout, 0);
    step();
    init_n = 1;
    wait_ack(1, 30, took);
    chk("regrant_latency", took, 20);
    dma.req = 0;
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      if (cpu.ack || (!cpu.req && $urandom_range(0, 3) == 0)) begin
        cpu.req = $urandom_range(0, 2) != 0; cpu.addr = 25'($urandom); cpu.we = 1'($urandom);
        cpu.din = 8'($urandom); cpu.aux = 1'($urandom);
      end
      if (dma.ack || (!dma.req && $urandom_range(0, 3) == 0)) begin
        dma.req = $urandom_range(0, 2) != 0; dma.addr = 25'($urandom); dma.we = 1'($urandom);
        dma.din = 8'($urandom); dma.aux = 1'($urandom);
      end
      if ($urandom_range(0, 299) == 0) ram_ready = !ram_ready;
      if ($urandom_range(0, 199) == 0) cpu.req = 0;
      if ($urandom_range(0, 199) == 0) hold_hi = !hold_hi;
      if ($urandom_range(0, 999) == 0) begin init_n = 0; step(); init_n = 1; end
    end
    step();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
